// File: rtl/led_pattern_gen.sv
// led_pattern_gen: run-time selectable LED pattern driver
// with tick/step prescalers and a breathe PWM.
module led_pattern_gen #(
  parameter int CLK_HZ   = 12000000,
  parameter int BLINK_HZ = 2,
  parameter int STEP_HZ  = 512,
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic [2:0]          MODE,
  output logic [NUM_LEDS-1:0] LEDS,
  output logic                TICK
);

  localparam int TICK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int STEP_DIV = CLK_HZ / STEP_HZ;
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(STEP_DIV + 1);
  localparam int PW = $clog2(NUM_LEDS);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(NUM_LEDS - 1);
  localparam logic [PW-1:0] POS_PEN   = PW'(NUM_LEDS - 2);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  typedef enum logic [2:0] {
    M_OFF     = 3'd0,
    M_ON      = 3'd1,
    M_BLINK   = 3'd2,
    M_CHASE   = 3'd3,
    M_BOUNCE  = 3'd4,
    M_BREATHE = 3'd5,
    M_COUNT   = 3'd6,
    M_RSVD    = 3'd7
  } mode_t;

  mode_t               mode_q;
  logic [TW-1:0]       tick_cnt;
  logic [SW-1:0]       step_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic                blink;
  logic [PW-1:0]       pos;
  logic                down;
  logic [NUM_LEDS-1:0] count;
  logic [NUM_LEDS-1:0] led_nxt;
  logic                mode_chg;
  logic                tick;
  logic                step;

  // A mode change wins over a coincident tick or step.
  assign mode_chg = (MODE != mode_q);
  assign tick = EN & ~mode_chg & (tick_cnt == TICK_LAST);
  assign step = EN & ~mode_chg & (step_cnt == STEP_LAST);

  always_comb begin
    led_nxt = '0;
    unique case (mode_q)
      M_ON:              led_nxt = '1;
      M_BLINK:           led_nxt = {NUM_LEDS{blink}};
      M_CHASE, M_BOUNCE: led_nxt[pos] = 1'b1;
      M_BREATHE:         led_nxt = {NUM_LEDS{pwm_cnt < duty}};
      M_COUNT:           led_nxt = count;
      default:           led_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q   <= M_OFF;
      tick_cnt <= '0;
      step_cnt <= '0;
      pwm_cnt  <= '0;
      duty     <= '0;
      blink    <= 1'b0;
      pos      <= '0;
      down     <= 1'b0;
      count    <= '0;
      LEDS     <= '0;
      TICK     <= 1'b0;
    end else begin
      TICK <= tick;
      if (EN) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        LEDS    <= led_nxt;
      end
      if (mode_chg) begin
        mode_q   <= mode_t'(MODE);
        tick_cnt <= '0;
        step_cnt <= '0;
        blink    <= 1'b0;
        pos      <= '0;
        down     <= 1'b0;
        duty     <= '0;
        count    <= '0;
      end else if (EN) begin
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
        step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + SW'(1);
        if (tick) begin
          case (mode_q)
            M_BLINK: blink <= ~blink;
            M_CHASE: pos <= (pos == POS_LAST) ? '0 : pos + PW'(1);
            M_BOUNCE: begin
              // Turn at the ends so each endpoint shows for one tick.
              if (down) begin
                pos <= pos - PW'(1);
                if (pos == PW'(1)) down <= 1'b0;
              end else begin
                pos <= pos + PW'(1);
                if (pos == POS_PEN) down <= 1'b1;
              end
            end
            M_COUNT: count <= count + NUM_LEDS'(1);
            default: ;
          endcase
        end
        if (step && (mode_q == M_BREATHE)) begin
          if (down) begin
            duty <= duty - PWM_BITS'(1);
            if (duty == PWM_BITS'(1)) down <= 1'b0;
          end else begin
            duty <= duty + PWM_BITS'(1);
            if (duty == DUTY_MAX - PWM_BITS'(1)) down <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed scoreboard bench for
// led_pattern_gen with a 4-clock tick and 2-clock step.
module tb_led_pattern_gen;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic [2:0] MODE;
  logic [3:0] LEDS;
  logic       TICK;

  int checks   = 0;
  int failures = 0;
  int pwm_m    = 0;
  int sidx     = 0;
  int sph      = 0;
  int cur_m    = 0;
  logic [3:0] last_l = '0;

  int bseq[6] = '{0, 1, 2, 3, 2, 1};
  int dtab[9] = '{0, 1, 2, 3, 2, 1, 0, 1, 2};

  typedef struct {
    string      tag;
    logic [3:0] l;
    logic       t;
  } req_t;
  req_t sb[$];

  always #5 CLK = ~CLK;

  led_pattern_gen #(
    .CLK_HZ(16), .BLINK_HZ(2), .STEP_HZ(8),
    .NUM_LEDS(4), .PWM_BITS(2)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE),
    .LEDS(LEDS), .TICK(TICK)
  );

  task automatic chk(input string tag, input logic [4:0] obs,
                     input logic [4:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s: observed leds,tick=%b required=%b",
             tag, obs, req);
    end
  endtask

  // One clock edge; the bench mirrors the free-running PWM phase.
  task automatic clk1();
    @(posedge CLK);
    if (!RST && EN) pwm_m = (pwm_m + 1) % 4;
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [3:0] l,
                          input logic t);
    req_t e;
    req_t o;
    e.tag = tag;
    e.l   = l;
    e.t   = t;
    sb.push_back(e);
    clk1();
    o = sb.pop_front();
    chk(o.tag, {LEDS, TICK}, {o.l, o.t});
  endtask

  function automatic logic [3:0] pat(input int m, input int i);
    case (m)
      1:       return 4'hF;
      2:       return (i % 2 == 1) ? 4'hF : 4'h0;
      3:       return 4'(1 << (i % 4));
      4:       return 4'(1 << bseq[i % 6]);
      6:       return 4'(i % 16);
      default: return 4'h0;
    endcase
  endfunction

  // Pattern index advances after the edge where TICK rises.
  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      last_l = pat(cur_m, sidx);
      step_chk(tag, last_l, sph == 3);
      if (sph == 3) sidx++;
      sph = (sph + 1) % 4;
    end
  endtask

  task automatic set_mode(input int m, input logic [3:0] l);
    MODE = 3'(m);
    step_chk("mode_change", l, 1'b0);
    cur_m = m;
    sidx  = 0;
    sph   = 0;
  endtask

  initial begin
    RST  = 1'b1;
    EN   = 1'b1;
    MODE = 3'd0;
    @(posedge CLK);
    #1;
    chk("reset_a", {LEDS, TICK}, 5'b0);
    @(posedge CLK);
    #1;
    chk("reset_b", {LEDS, TICK}, 5'b0);
    RST = 1'b0;
    run("off_tick", 8);

    set_mode(2, pat(0, 0));
    run("blink", 12);

    set_mode(3, pat(2, sidx));
    run("chase", 20);

    set_mode(4, pat(3, sidx));
    run("bounce", 32);

    set_mode(6, pat(4, sidx));
    run("count_a", 22);
    EN = 1'b0;
    for (int k = 0; k < 10; k++)
      step_chk("freeze", last_l, 1'b0);
    EN = 1'b1;
    run("count_b", 44);

    set_mode(5, pat(6, sidx));
    for (int k = 1; k <= 16; k++)
      step_chk("breathe", {4{pwm_m < dtab[(k - 1) / 2]}},
               (k % 4) == 0);

    set_mode(3, {4{pwm_m < dtab[8]}});
    run("chase2", 23);
    set_mode(6, pat(3, sidx));
    run("chg_on_tick", 8);

    set_mode(1, pat(6, sidx));
    run("on", 4);
    set_mode(7, 4'hF);
    run("reserved", 4);

    set_mode(3, 4'h0);
    run("chase3", 6);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst", {LEDS, TICK}, 5'b0);
    MODE  = 3'd0;
    pwm_m = 0;
    cur_m = 0;
    sidx  = 0;
    sph   = 0;
    @(posedge CLK);
    #1;
    chk("rst_hold", {LEDS, TICK}, 5'b0);
    RST = 1'b0;
    run("post_rst", 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
